instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the single-issue RV32I core. Holds the program counter, drives the word address of the asynchronous instruction memory, and captures each returned instruction with its PC into a 2-entry fetch buffer. The buffer feeds decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the target; a misaligned target raises a sticky fault.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- imem_addr  out  32  fetch address to instruction memory; equals the internal fetch_pc.
- imem_instr  in  32  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  one-cycle pulse from execute: taken branch, jal or jalr.
- redirect_pc  in  32  target address, sampled when redirect_valid=1.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction; 32'h00000013 (nop) when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.
- fault  out  1  sticky misaligned-redirect flag.

## Operation
- State:
  - fetch_pc (32b).
  - 2-entry FIFO of {pc, instr} with read pointer, write pointer and 2-bit count (0..2).
  - fault bit.
- imem_addr = fetch_pc, combinational.
- pop = out_valid & out_ready. out_valid = (count != 0).
- push occurs when all of the following hold: fault=0, redirect_valid=0, and (count<2 or pop). A push writes {fetch_pc, imem_instr} and advances fetch_pc by 4. Wrap is modulo 2^32, so 32'hFFFF_FFFC advances to 0.
- Push and pop in the same cycle with a full buffer is legal; count stays 2.
- Redirect (redirect_valid=1) has priority over push:
  - Any pop in that cycle completes normally.
  - All remaining entries are discarded, so count=0 after the edge. No push occurs.
  - If redirect_pc[1:0]=0: fetch_pc <= redirect_pc.
  - If redirect_pc[1:0]!=0: fault <= 1 and fetch_pc is unchanged.
- Fault state:
  - No pushes. Further redirects are ignored. out_valid remains 0.
  - Cleared only by rst_n.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, fault=0, fetch_pc=RESET_PC.
  - Outputs immediately: out_valid=0, out_instr=32'h00000013, out_pc=0, out_pc_plus4=4, fault=0, imem_addr=RESET_PC.
- Buffer storage is not cleared; outputs are masked by out_valid.

## Timing
- Let cycle 0 be the first rising edge after rst_n deasserts. That edge pushes RESET_PC, and out_valid=1 from cycle 1.
- Throughput: 1 instruction/cycle with out_ready held at 1, with no bubbles.
- Latency from fetch to head is 1 cycle when the buffer is empty.
- Backpressure with out_ready=0: the buffer fills on 2 edges and then fetch_pc holds at head PC + 8. When out_ready returns to 1, delivery continues in order with no gaps and no duplicates.
- Redirect asserted in cycle N:
  - Cycle N+1: out_valid=0 and imem_addr=target.
  - Cycle N+2: out_valid=1 with out_pc=target.
  - Penalty: 2 cycles.
- fault rises the cycle after the misaligned redirect.
- There are no combinational paths from out_ready or redirect_* to out_valid, out_instr or out_pc.

## Test plan
1. Reset release with out_ready=1, memory holding 0x00a00093 at 0x0 and 0xfec00113 at 0x4:
   - out_pc is 0x0, 0x4, 0x8 on consecutive cycles.
   - out_instr is 0x00a00093 then 0xfec00113.
   - out_pc_plus4=0x4 on the first transfer.
2. out_ready=0 for 5 cycles after reset, then 1:
   - count saturates at 2 and imem_addr holds 0x8.
   - out_pc=0x0 stable while stalled.
   - Afterwards 0x0, 0x4, 0x8 are delivered back-to-back, with none skipped or repeated.
3. Full buffer (PCs 0x0, 0x4), out_ready=1, redirect to 0xbc in the same cycle:
   - 0x0 is accepted.
   - Next cycle out_valid=0 and imem_addr=0xbc.
   - The cycle after, out_pc=0xbc and out_instr=0x00800f6f.
   - 0x4 is never delivered.
4. Redirect to 0x86:
   - fault=1 next cycle and out_valid stays 0 for 10 cycles.
   - A later redirect to 0x0 is ignored.
   - rst_n pulsed low mid-cycle clears fault and out_valid immediately, without waiting for an edge.
5. RESET_PC=32'hFFFF_FFF8 with out_ready=1: out_pc is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and out_pc_plus4 on the second transfer is 0x0.
6. Random out_ready (50%) plus random aligned redirects over 10k cycles:
   - A scoreboard checks strictly sequential PCs between redirects.
   - Each out_instr matches the memory contents at out_pc.
   - out_instr/out_pc are stable while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake: buffer head plus decode's accept.
interface instruction_fetch_if;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  modport master (output valid, instr, pc, pc_plus4, input ready);
  modport slave  (input valid, instr, pc, pc_plus4, output ready);
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, async imem addressing, 2-entry fetch buffer to decode,
// redirect flush and sticky misaligned-target fault.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_instr,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  instruction_fetch_if.master out,
  output logic                fault
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  fb_entry_t   fb_q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [31:0] fetch_pc;
  logic        fault_q;
  logic        pop, push, redir;

  assign imem_addr = fetch_pc;
  assign fault     = fault_q;

  // Outputs come only from registered state, so no ready/redirect -> valid path.
  assign out.valid    = (count != 2'd0);
  assign out.instr    = out.valid ? fb_q[rd_ptr].instr : NOP;
  assign out.pc       = out.valid ? fb_q[rd_ptr].pc : 32'h0;
  assign out.pc_plus4 = out.pc + 32'd4;

  assign pop   = out.valid & out.ready;
  assign redir = redirect_valid & ~fault_q;
  assign push  = ~fault_q & ~redirect_valid & ((count != 2'd2) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fault_q  <= 1'b0;
    end else if (redir) begin
      // Flush: the popped head (if any) already left; everything else is dropped.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      if (redirect_pc[1:0] == 2'b00) fetch_pc <= redirect_pc;
      else                           fault_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are masked by out.valid.
  always_ff @(posedge clk) begin
    if (push) fb_q[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized checks of instruction_fetch against a hand-computed
// memory image and an in-order PC scoreboard.
module tb_instruction_fetch;
  logic        clk, rst_n;
  logic [31:0] imem_addr, imem_instr, redirect_pc;
  logic        redirect_valid, fault;
  logic [31:0] imem_addr2, imem_instr2;
  logic        fault2;
  int          n_tests = 0;
  int          n_fail  = 0;

  instruction_fetch_if ifc ();
  instruction_fetch_if ifc2 ();

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out(ifc), .fault(fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out(ifc2), .fault(fault2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00a00093;
      32'h0000_0004: return 32'hfec00113;
      32'h0000_00bc: return 32'h00800f6f;
      default:       return a ^ 32'h5a5a_0003;
    endcase
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr2 = mem_word(imem_addr2);
  assign ifc2.ready  = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    ifc.ready = rdy;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_pc, prev_pc, prev_instr, tgt;
    logic        prev_hold, rdy, rd;

    rst_n = 1'b0;
    ifc.ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, ifc.valid}, 32'd0);
    chk("rst_instr", ifc.instr, 32'h0000_0013);
    chk("rst_pc", ifc.pc, 32'h0);
    chk("rst_pc4", ifc.pc_plus4, 32'h4);
    chk("rst_imem", imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_imem2", imem_addr2, 32'hFFFF_FFF8);

    // Test 1 + wrap test on the second instance.
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_valid", {31'b0, ifc.valid}, 32'd1);
    chk("t1_pc0", ifc.pc, 32'h0);
    chk("t1_instr0", ifc.instr, 32'h00a00093);
    chk("t1_pc4_0", ifc.pc_plus4, 32'h4);
    chk("t5_pc0", ifc2.pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("t1_pc1", ifc.pc, 32'h4);
    chk("t1_instr1", ifc.instr, 32'hfec00113);
    chk("t5_pc1", ifc2.pc, 32'hFFFF_FFFC);
    chk("t5_pc4_1", ifc2.pc_plus4, 32'h0);
    @(negedge clk);
    chk("t1_pc2", ifc.pc, 32'h8);
    chk("t5_pc2", ifc2.pc, 32'h0);

    // Test 2: backpressure.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_pc", ifc.pc, 32'h0);
      chk("t2_stall_valid", {31'b0, ifc.valid}, 32'd1);
      if (i >= 1) chk("t2_stall_imem", imem_addr, 32'h8);
    end
    ifc.ready = 1'b1;
    @(negedge clk);
    chk("t2_drain_pc4", ifc.pc, 32'h4);
    @(negedge clk);
    chk("t2_drain_pc8", ifc.pc, 32'h8);
    @(negedge clk);
    chk("t2_drain_pcc", ifc.pc, 32'hc);

    // Test 3: redirect with full buffer and a same-cycle pop.
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    chk("t3_full_imem", imem_addr, 32'h8);
    chk("t3_head", ifc.pc, 32'h0);
    ifc.ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00bc;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_bubble_valid", {31'b0, ifc.valid}, 32'd0);
    chk("t3_bubble_imem", imem_addr, 32'hbc);
    @(negedge clk);
    chk("t3_tgt_valid", {31'b0, ifc.valid}, 32'd1);
    chk("t3_tgt_pc", ifc.pc, 32'hbc);
    chk("t3_tgt_instr", ifc.instr, 32'h00800f6f);
    @(negedge clk);
    chk("t3_next_pc", ifc.pc, 32'hc0);

    // Test 4: misaligned redirect -> sticky fault.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0086;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_fault", {31'b0, fault}, 32'd1);
    chk("t4_imem_hold", imem_addr, 32'hc4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_no_valid", {31'b0, ifc.valid}, 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_ignored_imem", imem_addr, 32'hc4);
    chk("t4_ignored_valid", {31'b0, ifc.valid}, 32'd0);
    chk("t4_still_fault", {31'b0, fault}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_fault", {31'b0, fault}, 32'd0);
    chk("t4_async_valid", {31'b0, ifc.valid}, 32'd0);
    chk("t4_async_imem", imem_addr, 32'h0);
    @(negedge clk);

    // Test 6: random ready and aligned redirects against an in-order scoreboard.
    do_reset(1'b1);
    exp_pc = 32'h0;
    prev_hold = 1'b0;
    prev_pc = 32'h0;
    prev_instr = 32'h0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (prev_hold) begin
        chk("t6_hold_pc", ifc.pc, prev_pc);
        chk("t6_hold_instr", ifc.instr, prev_instr);
      end
      if (ifc.valid) begin
        chk("t6_seq_pc", ifc.pc, exp_pc);
        chk("t6_instr", ifc.instr, mem_word(ifc.pc));
      end
      rdy = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 19) == 0);
      tgt = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      ifc.ready = rdy;
      redirect_valid = rd;
      redirect_pc = tgt;
      if (rd) exp_pc = tgt;
      else if (ifc.valid && rdy) exp_pc = ifc.pc + 32'd4;
      prev_hold  = ifc.valid & ~rdy & ~rd;
      prev_pc    = ifc.pc;
      prev_instr = ifc.instr;
    end
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t6_no_fault", {31'b0, fault}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
